// File: rtl/dot_arbiter.sv
// ---------------------------------------------------------------------------
// dot_arbiter
//
// Shares one in-order dot-product unit between N_REQ requesters. Each
// requester presents the head of its operand FIFO (x and y 3-vectors). A
// combinational round-robin picks one non-empty requester and presents its
// operands to the dot unit as a FIFO head. When the dot unit pops, the
// requester's FIFO is popped in the same cycle and the requester ID is pushed
// into a tag FIFO. Results are returned together with the tag at the tag FIFO
// head. Because the dot unit is in-order, that tag always belongs to the
// result at dot_out.
//
// A flush request stops new issues and waits for the in-flight operations to
// drain. flush_done is high while the arbiter sits drained in IDLE.
//
// Ports
//   clock, reset            rising-edge clock, asynchronous active-low reset
//   req_x, req_y            per-requester operand heads, requester r, element e
//                           at bits [(r*3+e)*DATA_WIDTH +: DATA_WIDTH]
//   req_empty / req_rd_en   per-requester FIFO empty / pop (one-hot or zero)
//   dot_x, dot_y            operands to the dot unit, element e at
//                           [e*DATA_WIDTH +: DATA_WIDTH]
//   dot_in_empty/_rd_en     operand FIFO interface seen by the dot unit
//   dot_out, dot_out_empty  dot unit result head
//   dot_out_rd_en           pop of the dot unit result
//   res_dout, res_tag       result and the ID of the requester that issued it
//   res_empty / res_rd_en   result FIFO interface toward the consumer
//   flush / flush_done      stop-and-drain request / drained indication
//   inflight                number of issued but not yet retired operations
// ---------------------------------------------------------------------------
module dot_arbiter #(
    parameter int N_REQ      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_DEPTH  = 16,
    localparam int TAG_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [N_REQ*3*DATA_WIDTH-1:0]   req_x,
    input  logic [N_REQ*3*DATA_WIDTH-1:0]   req_y,
    input  logic [N_REQ-1:0]                req_empty,
    output logic [N_REQ-1:0]                req_rd_en,
    output logic [3*DATA_WIDTH-1:0]         dot_x,
    output logic [3*DATA_WIDTH-1:0]         dot_y,
    output logic                            dot_in_empty,
    input  logic                            dot_in_rd_en,
    input  logic [DATA_WIDTH-1:0]           dot_out,
    input  logic                            dot_out_empty,
    output logic                            dot_out_rd_en,
    output logic [DATA_WIDTH-1:0]           res_dout,
    output logic [TAG_W-1:0]                res_tag,
    output logic                            res_empty,
    input  logic                            res_rd_en,
    input  logic                            flush,
    output logic                            flush_done,
    output logic [$clog2(TAG_DEPTH):0]      inflight
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int VEC_W = 3 * DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    // Round-robin pick. Returns {valid, grant}. The loop walks the search
    // order backwards so the last hit is the first requester after 'last'.
    function automatic logic [TAG_W:0] rr_pick(
        input logic [TAG_W-1:0] last,
        input logic [N_REQ-1:0] empty
    );
        logic [TAG_W:0]   result;
        logic [TAG_W-1:0] idx;
        result = {1'b0, last};
        for (int i = N_REQ; i >= 1; i--) begin
            idx = TAG_W'((int'(last) + i) % N_REQ);
            if (!empty[idx]) begin
                result = {1'b1, idx};
            end else begin
                result = result;
            end
        end
        return result;
    endfunction

    state_t               r_state;
    state_t               w_next_state;
    logic [TAG_W-1:0]     r_last_grant;
    logic [TAG_W-1:0]     r_tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;

    logic [TAG_W:0]       w_pick;
    logic                 w_req_any;
    logic [TAG_W-1:0]     w_grant;
    logic                 w_tag_full;
    logic                 w_tag_empty;
    logic                 w_in_empty;
    logic                 w_res_empty;
    logic                 w_issue;
    logic                 w_retire;
    logic [VEC_W-1:0]     w_dot_x;
    logic [VEC_W-1:0]     w_dot_y;
    logic [N_REQ-1:0]     w_req_rd_en;
    logic                 w_flush_done;

    // Arbitration and the issue/retire handshakes. reset is folded in so the
    // handshake outputs are quiet while reset is held, not just after a clock.
    always_comb begin
        w_pick      = rr_pick(r_last_grant, req_empty);
        w_req_any   = w_pick[TAG_W];
        w_grant     = w_pick[TAG_W-1:0];
        w_tag_full  = (r_count == CNT_W'(TAG_DEPTH));
        w_tag_empty = (r_count == {CNT_W{1'b0}});
        // A full tag FIFO blocks issue even if a retire frees a slot this cycle.
        w_in_empty  = !reset || (r_state != ST_RUN) || !w_req_any || w_tag_full;
        w_res_empty = !reset || dot_out_empty || w_tag_empty;
        w_issue     = dot_in_rd_en && !w_in_empty;
        w_retire    = res_rd_en && !w_res_empty;
    end

    // Operand mux and per-requester pop decode for the granted requester.
    always_comb begin
        w_dot_x     = {VEC_W{1'b0}};
        w_dot_y     = {VEC_W{1'b0}};
        w_req_rd_en = {N_REQ{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            w_dot_x        = (w_grant == TAG_W'(i)) ? req_x[i*VEC_W +: VEC_W] : w_dot_x;
            w_dot_y        = (w_grant == TAG_W'(i)) ? req_y[i*VEC_W +: VEC_W] : w_dot_y;
            w_req_rd_en[i] = w_issue && (w_grant == TAG_W'(i));
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic. A DRAIN entered by a flush that is withdrawn
    // still finishes draining, then resumes directly in RUN.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN: begin
                if (flush) begin
                    w_next_state = ST_DRAIN;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (r_count != {CNT_W{1'b0}}) begin
                    w_next_state = ST_DRAIN;
                end else if (flush) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_IDLE: begin
                if (flush) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    // FSM outputs.
    always_comb begin
        w_flush_done = (r_state == ST_IDLE);
    end

    // Round-robin pointer; N_REQ-1 after reset makes requester 0 win first.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_grant <= TAG_W'(N_REQ - 1);
        end else if (w_issue) begin
            r_last_grant <= w_grant;
        end else begin
            r_last_grant <= r_last_grant;
        end
    end

    // Tag FIFO storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (w_issue) begin
            r_tag_mem[r_wr_ptr] <= w_grant;
        end
    end

    // Tag FIFO pointers and occupancy (the occupancy is the inflight count).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_issue) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_retire) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_issue, w_retire})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign req_rd_en     = w_req_rd_en;
    assign dot_x         = w_dot_x;
    assign dot_y         = w_dot_y;
    assign dot_in_empty  = w_in_empty;
    assign dot_out_rd_en = w_retire;
    assign res_dout      = dot_out;
    assign res_tag       = r_tag_mem[r_rd_ptr];
    assign res_empty     = w_res_empty;
    assign flush_done    = w_flush_done;
    assign inflight      = r_count;

endmodule
